// File: rtl/gate_driver_spi_phy.sv
// SPI mode-1 master for the gate-driver link: one 16-bit frame per
// request, with a chip-select setup/hold/idle envelope and read-back of
// the 11-bit register payload.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus idle, waiting for a write or read request
// SETUP | nSCS low, SCLK low, first bit on SDI, CS_SETUP cycles
// SHIFT | 16 SCLK periods, SDI driven on rise, SDO sampled on fall
// HOLD  | SCLK low, nSCS still low, CS_HOLD cycles
// GAP   | nSCS high, still busy, CS_IDLE cycles
// DONE  | one-cycle completion pulse, busy low, requests ignored
module gate_driver_spi_phy #(
   parameter int FRAME_WIDTH = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int SCLK_DIV    = 10,
   parameter int CS_SETUP    = 5,
   parameter int CS_HOLD     = 5,
   parameter int CS_IDLE     = 10
) (
   input  logic                   sys_clk,
   input  logic                   reset_n,
   input  logic [FRAME_WIDTH-1:0] wr_data_in,
   input  logic                   wr_data_enable_in,
   input  logic [DATA_WIDTH-1:0]  rd_addr_in,
   input  logic                   rd_data_enable_in,
   output logic [FRAME_WIDTH-1:0] rd_data_out,
   output logic                   spi_phy_proc_done_out,
   output logic                   spi_phy_proc_busy_out,
   output logic                   spi_sclk_out,
   output logic                   spi_nscs_out,
   output logic                   spi_sdi_out,
   input  logic                   spi_sdo_in
);

   // One down-counter serves every timed phase, so it is sized for the
   // longest of them (never narrower than a full SCLK period).
   localparam int MAX_A   = (2 * SCLK_DIV > CS_SETUP) ? 2 * SCLK_DIV : CS_SETUP;
   localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int BIT_W   = $clog2(FRAME_WIDTH);

   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(CS_IDLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, HOLD, GAP, DONE
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic [FRAME_WIDTH-1:0] tx;
   logic [FRAME_WIDTH-1:0] rx;
   logic                   is_rd;
   logic [FRAME_WIDTH-1:0] wr_frame;
   logic [FRAME_WIDTH-1:0] rd_frame;

   // Only the low address nibble and the 15 write payload bits reach the wire.
   logic unused_bits;
   assign unused_bits = ^{wr_data_in[FRAME_WIDTH-1], rd_addr_in[DATA_WIDTH-1:4]};

   // Frames as they go on the wire: bit 15 is the read/write flag.
   assign wr_frame = {1'b0, wr_data_in[FRAME_WIDTH-2:0]};
   assign rd_frame = {1'b1, rd_addr_in[3:0], {(FRAME_WIDTH - 5){1'b0}}};

   // Frame sequencer; every pin and status output is a register of this block.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state                 <= IDLE;
         cnt                   <= '0;
         bit_cnt               <= '0;
         tx                    <= '0;
         rx                    <= '0;
         is_rd                 <= 1'b0;
         rd_data_out           <= '0;
         spi_phy_proc_done_out <= 1'b0;
         spi_phy_proc_busy_out <= 1'b0;
         spi_sclk_out          <= 1'b0;
         spi_nscs_out          <= 1'b1;
         spi_sdi_out           <= 1'b0;
      end else begin
         spi_phy_proc_done_out <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               // Write wins when both enables arrive together.
               if (wr_data_enable_in || rd_data_enable_in) begin
                  tx                    <= wr_data_enable_in ? wr_frame : rd_frame;
                  spi_sdi_out           <= wr_data_enable_in ? wr_frame[FRAME_WIDTH-1]
                                                             : rd_frame[FRAME_WIDTH-1];
                  is_rd                 <= !wr_data_enable_in;
                  spi_nscs_out          <= 1'b0;
                  spi_phy_proc_busy_out <= 1'b1;
                  cnt                   <= SETUP_LOAD;
                  state                 <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  spi_sclk_out <= 1'b1;
                  cnt          <= HALF_LOAD;
                  state        <= SHIFT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (spi_sclk_out) begin
                  spi_sclk_out <= 1'b0;
                  rx           <= {rx[FRAME_WIDTH-2:0], spi_sdo_in};
                  cnt          <= HALF_LOAD;
               end else if (bit_cnt == LAST_BIT) begin
                  cnt   <= HOLD_LOAD;
                  state <= HOLD;
               end else begin
                  spi_sclk_out <= 1'b1;
                  spi_sdi_out  <= tx[FRAME_WIDTH-2];
                  tx           <= tx << 1;
                  bit_cnt      <= bit_cnt + 1'b1;
                  cnt          <= HALF_LOAD;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  spi_nscs_out <= 1'b1;
                  cnt          <= IDLE_LOAD;
                  state        <= GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  spi_phy_proc_done_out <= 1'b1;
                  spi_phy_proc_busy_out <= 1'b0;
                  if (is_rd)
                     rd_data_out <= {5'b0, rx[FRAME_WIDTH-6:0]};
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_driver_spi_phy.sv
// Directed bench for gate_driver_spi_phy: writes, reads, request
// collisions, controller handshake and reset abort, with a pin monitor
// and an SPI slave model answering on SDO.
module tb_gate_driver_spi_phy;

   localparam int L_DONE    = 341;
   localparam int NSCS_UP   = 331;
   localparam int FIRST_UP  = 6;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] wr_data_in = '0;
   logic        wr_data_enable_in = 1'b0;
   logic [15:0] rd_addr_in = '0;
   logic        rd_data_enable_in = 1'b0;
   logic [15:0] rd_data_out;
   logic        spi_phy_proc_done_out;
   logic        spi_phy_proc_busy_out;
   logic        spi_sclk_out;
   logic        spi_nscs_out;
   logic        spi_sdi_out;
   logic        spi_sdo_in = 1'b0;

   int total = 0;
   int bad   = 0;

   gate_driver_spi_phy dut (
      .sys_clk               (sys_clk),
      .reset_n               (reset_n),
      .wr_data_in            (wr_data_in),
      .wr_data_enable_in     (wr_data_enable_in),
      .rd_addr_in            (rd_addr_in),
      .rd_data_enable_in     (rd_data_enable_in),
      .rd_data_out           (rd_data_out),
      .spi_phy_proc_done_out (spi_phy_proc_done_out),
      .spi_phy_proc_busy_out (spi_phy_proc_busy_out),
      .spi_sclk_out          (spi_sclk_out),
      .spi_nscs_out          (spi_nscs_out),
      .spi_sdi_out           (spi_sdi_out),
      .spi_sdo_in            (spi_sdo_in)
   );

   // 100 MHz system clock
   initial forever #5 sys_clk = ~sys_clk;

   int cyc = 0;
   int req_cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Slave model: loads its response on nSCS fall, drives the next bit on each SCLK rise.
   logic [15:0] resp = 16'h0000;
   logic [15:0] sdo_sh = 16'h0000;
   always @(negedge spi_nscs_out or posedge spi_sclk_out) begin
      if (spi_sclk_out) begin
         spi_sdo_in = sdo_sh[15];
         sdo_sh     = {sdo_sh[14:0], 1'b0};
      end else begin
         sdo_sh = resp;
      end
   end

   // Pin monitor: per-frame edge counts, SDI capture on rises, protocol violations.
   int          frames = 0, done_cnt = 0, viol = 0, cur = 0;
   int          rises = 0, falls = 0, first_rise = -1;
   logic [15:0] cap = '0;
   int          f_fall[8], f_first[8], f_rise_n[8], f_fall_n[8], f_up[8];
   logic [15:0] f_cap[8];
   logic        p_sclk = 1'b0, p_nscs = 1'b1, p_sdi = 1'b0;
   always @(negedge sys_clk) begin : mon
      int rel;
      rel = cyc - req_cyc;
      if (p_nscs && !spi_nscs_out) begin
         cur = frames % 8;
         frames++;
         f_fall[cur] = rel;
         rises = 0; falls = 0; cap = '0; first_rise = -1;
      end
      if (!p_sclk && spi_sclk_out) begin
         rises++;
         cap = {cap[14:0], spi_sdi_out};
         if (rises == 1) first_rise = rel;
      end
      if (p_sclk && !spi_sclk_out) falls++;
      if (!p_nscs && spi_nscs_out) begin
         f_up[cur] = rel; f_cap[cur] = cap; f_rise_n[cur] = rises;
         f_fall_n[cur] = falls; f_first[cur] = first_rise;
      end
      if ((spi_sclk_out !== p_sclk) && p_nscs && spi_nscs_out) viol++;
      if ((spi_sdi_out !== p_sdi) && !(!p_sclk && spi_sclk_out) && !p_nscs && !spi_nscs_out) viol++;
      if (spi_phy_proc_done_out) done_cnt++;
      p_sclk = spi_sclk_out; p_nscs = spi_nscs_out; p_sdi = spi_sdi_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue a one-cycle request at a negedge; afterwards we sit at relative cycle 1.
   task automatic do_req(input bit wr, input bit rd, input logic [15:0] wd,
                         input logic [15:0] ad, input string tag);
      @(negedge sys_clk);
      wr_data_in = wd; rd_addr_in = ad;
      wr_data_enable_in = wr; rd_data_enable_in = rd;
      req_cyc = cyc;
      @(negedge sys_clk);
      wr_data_enable_in = 1'b0; rd_data_enable_in = 1'b0;
      check({tag, "_busy_c1"}, spi_phy_proc_busy_out, 1'b1);
      check({tag, "_nscs_c1"}, spi_nscs_out, 1'b0);
   endtask

   task automatic wait_done(input string tag, output int rel);
      int n;
      n = 0;
      while (spi_phy_proc_done_out !== 1'b1 && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_done_seen"}, spi_phy_proc_done_out, 1'b1);
      rel = cyc - req_cyc;
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp_sdi);
      int i;
      i = (frames - 1) % 8;
      check({tag, "_sdi"}, f_cap[i], exp_sdi);
      check({tag, "_rises"}, f_rise_n[i], 16);
      check({tag, "_falls"}, f_fall_n[i], 16);
   endtask

   initial begin
      int rel, f0, d0, n;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_nscs", spi_nscs_out, 1'b1);
      check("rst_sclk", spi_sclk_out, 1'b0);
      check("rst_sdi", spi_sdi_out, 1'b0);
      check("rst_busy", spi_phy_proc_busy_out, 1'b0);
      check("rst_done", spi_phy_proc_done_out, 1'b0);
      check("rst_rd", rd_data_out, 16'h0000);
      reset_n = 1'b1;
      repeat (3) @(negedge sys_clk);

      // Write: bit 15 forced low, full timing envelope
      resp = 16'hFFFF;
      do_req(1'b1, 1'b0, 16'h9234, 16'h0, "wr");
      wait_done("wr", rel);
      check("wr_done_cyc", rel, L_DONE);
      check("wr_busy_at_done", spi_phy_proc_busy_out, 1'b0);
      check("wr_rd_unchanged", rd_data_out, 16'h0000);
      check_frame("wr", 16'h1234);
      check("wr_nscs_fall", f_fall[(frames - 1) % 8], 1);
      check("wr_first_rise", f_first[(frames - 1) % 8], FIRST_UP);
      check("wr_nscs_rise", f_up[(frames - 1) % 8], NSCS_UP);
      @(negedge sys_clk);
      check("wr_done_pulse", spi_phy_proc_done_out, 1'b0);

      // Reads of address 1 with two slave responses
      resp = 16'hFFFF;
      do_req(1'b0, 1'b1, 16'h0, 16'h0001, "rd1");
      wait_done("rd1", rel);
      check("rd1_done_cyc", rel, L_DONE);
      check("rd1_data", rd_data_out, 16'h07FF);
      check_frame("rd1", 16'h8800);
      @(negedge sys_clk);

      resp = 16'hA5C3;
      do_req(1'b0, 1'b1, 16'h0, 16'hFFF1, "rd2");
      wait_done("rd2", rel);
      check("rd2_data", rd_data_out, 16'h05C3);
      check_frame("rd2", 16'h8800);
      @(negedge sys_clk);

      // Both enables together: only the write goes out
      f0 = frames;
      resp = 16'h1111;
      do_req(1'b1, 1'b1, 16'h00AB, 16'h0003, "col");
      wait_done("col", rel);
      check_frame("col", 16'h00AB);
      check("col_rd_kept", rd_data_out, 16'h05C3);
      repeat (20) @(negedge sys_clk);
      check("col_one_frame", frames - f0, 1);

      // Read pulse in the middle of an active frame is dropped
      f0 = frames; d0 = done_cnt;
      do_req(1'b1, 1'b0, 16'h4321, 16'h0, "ign");
      while (cyc - req_cyc < 100) @(negedge sys_clk);
      rd_addr_in = 16'h0002; rd_data_enable_in = 1'b1;
      @(negedge sys_clk);
      rd_data_enable_in = 1'b0;
      wait_done("ign", rel);
      check("ign_done_cyc", rel, L_DONE);
      check_frame("ign", 16'h4321);
      repeat (400) @(negedge sys_clk);
      check("ign_frames", frames - f0, 1);
      check("ign_dones", done_cnt - d0, 1);

      // Controller handshake: read 0 then read 1, issued on !busy && !done
      f0 = frames;
      resp = 16'h0000;
      @(negedge sys_clk);
      rd_addr_in = 16'h0000; rd_data_enable_in = 1'b1; req_cyc = cyc;
      @(negedge sys_clk);
      rd_data_enable_in = 1'b0;
      n = 0;
      while ((spi_phy_proc_busy_out || spi_phy_proc_done_out) && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      check("hs_wait_bound", n < 1000, 1'b1);
      check("hs_frame0_sdi", f_cap[(frames - 1) % 8], 16'h8000);
      rd_addr_in = 16'h0001; rd_data_enable_in = 1'b1;
      @(negedge sys_clk);
      rd_data_enable_in = 1'b0;
      wait_done("hs", rel);
      check("hs_frames", frames - f0, 2);
      check("hs_second_fall", f_fall[(frames - 1) % 8], 343);
      check_frame("hs1", 16'h8800);
      check("hs_rd_data", rd_data_out, 16'h0000);
      @(negedge sys_clk);

      // Reset in mid-frame aborts at once, no done
      resp = 16'h5555;
      do_req(1'b1, 1'b0, 16'h7FFF, 16'h0, "abt");
      d0 = done_cnt;
      while (cyc - req_cyc < 150) @(negedge sys_clk);
      reset_n = 1'b0;
      #1;
      check("abt_nscs", spi_nscs_out, 1'b1);
      check("abt_sclk", spi_sclk_out, 1'b0);
      check("abt_busy", spi_phy_proc_busy_out, 1'b0);
      repeat (2) @(negedge sys_clk);
      reset_n = 1'b1;
      repeat (400) @(negedge sys_clk);
      check("abt_no_done", done_cnt - d0, 0);
      check("abt_rd_cleared", rd_data_out, 16'h0000);

      resp = 16'h1234;
      do_req(1'b0, 1'b1, 16'h0, 16'h0002, "post");
      wait_done("post", rel);
      check("post_done_cyc", rel, L_DONE);
      check("post_rd", rd_data_out, 16'h0234);
      check_frame("post", 16'h9000);
      repeat (5) @(negedge sys_clk);

      check("protocol_viol", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
